// File: rtl/apb2axi_axi_responder.sv
// AXI3 subordinate responder: serves AR/AW/W bursts from a small internal
// word memory, with optional idle gaps between R beats and SLVERR on
// out-of-range or malformed bursts. Read and write sides run independently.
module apb2axi_axi_responder #(
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MEM_DEPTH  = 16,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned RVALID_GAP = 0
) (
  input  logic                  aclk,
  input  logic                  areset,
  // read address channel
  input  logic [TAG_W-1:0]      arid,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [3:0]            arlen,
  input  logic                  arvalid,
  output logic                  arready,
  // read data channel
  output logic [TAG_W-1:0]      rid,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  // write address channel
  input  logic [TAG_W-1:0]      awid,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [3:0]            awlen,
  input  logic                  awvalid,
  output logic                  awready,
  // write data channel
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  // write response channel
  output logic [TAG_W-1:0]      bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int unsigned BYTES    = DATA_W / 8;
  localparam int unsigned BYTE_SH  = $clog2(BYTES);
  localparam int unsigned IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned GAP_W    = (RVALID_GAP > 1) ? $clog2(RVALID_GAP) : 1;
  localparam int unsigned GAP_LAST = (RVALID_GAP > 0) ? RVALID_GAP - 1 : 0;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] SPAN_A = ADDR_W'(MEM_DEPTH * BYTES);
  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(BYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_GAP}  r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  // Addresses below BASE wrap to large offsets, so one compare covers both bounds.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a - BASE_A) < SPAN_A;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = (a - BASE_A) >> BYTE_SH;
    return IDX_W'(off);
  endfunction

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  r_state_e          r_state_q, r_state_d;
  logic [TAG_W-1:0]  r_id_q, r_id_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [3:0]        r_len_q, r_len_d;
  logic [3:0]        r_beat_q, r_beat_d;
  logic [GAP_W-1:0]  r_gap_q, r_gap_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;

  w_state_e          w_state_q, w_state_d;
  logic [TAG_W-1:0]  w_id_q, w_id_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [3:0]        w_len_q, w_len_d;
  logic [3:0]        w_beat_q, w_beat_d;
  logic              w_err_q, w_err_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;

  logic              r_in_rng_c;
  logic              r_last_c;
  logic [IDX_W-1:0]  r_idx_c;
  logic              w_in_rng_c;
  logic              w_last_c;
  logic [IDX_W-1:0]  w_idx_c;
  logic              mem_we_c;

  assign r_in_rng_c = in_range(r_addr_q);
  assign r_idx_c    = word_idx(r_addr_q);
  assign r_last_c   = (r_beat_q == r_len_q);
  assign w_in_rng_c = in_range(w_addr_q);
  assign w_idx_c    = word_idx(w_addr_q);
  assign w_last_c   = (w_beat_q == w_len_q);

  // R channel outputs decoded from registered state; memory read is pre-write.
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = r_id_q;
  assign rlast   = rvalid_q && r_last_c;
  assign rresp   = (rvalid_q && !r_in_rng_c) ? RESP_SLVERR : RESP_OKAY;
  assign rdata   = (rvalid_q && r_in_rng_c) ? mem_q[r_idx_c] : '0;

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = w_id_q;
  assign bresp   = (bvalid_q && w_err_q) ? RESP_SLVERR : RESP_OKAY;

  // Read FSM next state: address capture, beat stepping and inter-beat gap.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_gap_d   = r_gap_q;
    arready_d = 1'b0;
    rvalid_d  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          r_id_d    = arid;
          r_addr_d  = araddr;
          r_len_d   = arlen;
          r_beat_d  = 4'd0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && rready) begin
          if (r_last_c) begin
            r_state_d = R_IDLE;
          end else begin
            r_beat_d = r_beat_q + 4'd1;
            r_addr_d = r_addr_q + STEP_A;
            if (RVALID_GAP > 0) begin
              r_gap_d   = '0;
              r_state_d = R_GAP;
            end
          end
        end
      end
      R_GAP: begin
        if (r_gap_q == GAP_W'(GAP_LAST)) begin
          r_state_d = R_DATA;
        end else begin
          r_gap_d = r_gap_q + GAP_W'(1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  // Read FSM state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_gap_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_gap_q   <= r_gap_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Write FSM next state: beat counting, error accumulation, memory write enable.
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_err_d   = w_err_q;
    mem_we_c  = 1'b0;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    bvalid_d  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          w_id_d    = awid;
          w_addr_d  = awaddr;
          w_len_d   = awlen;
          w_beat_d  = 4'd0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          mem_we_c = w_in_rng_c;
          if (!w_in_rng_c || (wlast != w_last_c)) begin
            w_err_d = 1'b1;
          end
          // Burst length comes from awlen only; an early wlast is just an error.
          if (w_last_c) begin
            w_state_d = W_RESP;
          end else begin
            w_beat_d = w_beat_q + 4'd1;
            w_addr_d = w_addr_q + STEP_A;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Write FSM state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Word memory with per-byte strobes, cleared by reset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we_c) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (wstrb[b]) begin
          mem_q[w_idx_c][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb2axi_axi_responder.sv
// Scoreboard bench for apb2axi_axi_responder: drivers push expected R/B
// responses from a word-array model; a monitor pops and compares them.
module tb_apb2axi_axi_responder;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned GAP = 2;
  localparam logic [31:0] BASE = 32'h0000_0100;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_beat_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_rsp_t;

  logic        aclk, areset;
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arlen, awlen;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [63:0] rdata, wdata;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready;

  r_beat_t     r_exp[$];
  b_rsp_t      b_exp[$];
  logic [63:0] model [DEPTH];
  logic [63:0] wb_data [16];
  logic [7:0]  wb_strb [16];
  logic        wb_last [16];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int rr_mode = 0;
  int br_mode = 0;
  int exp_b_cyc = 0;
  bit exp_b_v = 0;

  apb2axi_axi_responder #(
    .TAG_W(TAG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH),
    .BASE_ADDR(BASE), .RVALID_GAP(GAP)
  ) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    forever begin
      @(posedge aclk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compared = compared + 1;
    if (act !== exp) begin
      mismatched = mismatched + 1;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string nm);
    compared = compared + 1;
    mismatched = mismatched + 1;
    $display("FAIL %s: got unexpected event or timeout, expected none (cycle %0d)", nm, cyc);
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(DEPTH * 8));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 64'd0;
  endtask

  // Ready generators: 0 = always, 1 = toggle each cycle, 2 = random.
  initial begin
    rready = 1'b0;
    bready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (rr_mode)
        0: rready = 1'b1;
        1: rready = ~rready;
        default: rready = ($urandom_range(0, 3) != 0);
      endcase
      case (br_mode)
        0: bready = 1'b1;
        1: bready = ~bready;
        default: bready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: scoreboard pops, stall stability, and R/B valid timing.
  initial begin
    r_beat_t cur_r, saved_r, e;
    b_rsp_t  cur_b, saved_b, eb;
    logic prev_rvalid, prev_rstall, prev_bvalid, prev_bstall;
    int exp_rise;
    bit exp_rise_v;
    prev_rvalid = 0; prev_rstall = 0; prev_bvalid = 0; prev_bstall = 0;
    exp_rise = 0; exp_rise_v = 0;
    saved_r = '0; saved_b = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_rvalid = 0; prev_rstall = 0; exp_rise_v = 0;
        prev_bvalid = 0; prev_bstall = 0; exp_b_v = 0;
      end else begin
        cur_r = {rid, rdata, rresp, rlast};
        if (prev_rstall) chk("r_stall_hold", {rvalid, cur_r}, {1'b1, saved_r});
        if (exp_rise_v && cyc < exp_rise) chk("r_gap_idle", rvalid, 1'b0);
        if (rvalid && !prev_rvalid) begin
          if (exp_rise_v) chk("r_valid_timing", cyc, exp_rise);
          else fail_evt("r_valid_unexpected");
          exp_rise_v = 0;
        end
        if (rvalid && rready) begin
          if (r_exp.size() == 0) fail_evt("r_beat_unexpected");
          else begin
            e = r_exp.pop_front();
            chk("r_beat", cur_r, e);
          end
          if (!rlast) begin
            exp_rise = cyc + 1 + int'(GAP);
            exp_rise_v = 1;
          end
        end
        if (arvalid && arready) begin
          exp_rise = cyc + 1;
          exp_rise_v = 1;
        end
        prev_rstall = rvalid && !rready;
        prev_rvalid = rvalid;
        saved_r = cur_r;

        cur_b = {bid, bresp};
        if (prev_bstall) chk("b_stall_hold", {bvalid, cur_b}, {1'b1, saved_b});
        if (bvalid && !prev_bvalid) begin
          if (exp_b_v) chk("b_valid_timing", cyc, exp_b_cyc);
          else fail_evt("b_valid_unexpected");
          exp_b_v = 0;
        end
        if (bvalid && bready) begin
          if (b_exp.size() == 0) fail_evt("b_unexpected");
          else begin
            eb = b_exp.pop_front();
            chk("b_resp", cur_b, eb);
          end
        end
        prev_bstall = bvalid && !bready;
        prev_bvalid = bvalid;
        saved_b = cur_b;
      end
    end
  end

  // Push expected R beats for a burst and perform the AR handshake.
  task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input int len);
    r_beat_t e;
    logic [31:0] a;
    bit ok;
    for (int n = 0; n <= len; n++) begin
      a = addr + 32'(n * 8);
      e.id = id;
      if (in_rng(a)) begin
        e.data = model[widx(a)];
        e.resp = 2'b00;
      end else begin
        e.data = 64'd0;
        e.resp = 2'b10;
      end
      e.last = (n == len);
      r_exp.push_back(e);
    end
    @(posedge aclk);
    #1;
    arid = id; araddr = addr; arlen = 4'(len); arvalid = 1'b1;
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge aclk);
      if (arready) ok = 1;
    end
    if (!ok) fail_evt("ar_handshake_timeout");
    @(posedge aclk);
    #1;
    arvalid = 1'b0;
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len);
    issue_ar(id, addr, len);
    for (int k = 0; k < 600 && r_exp.size() != 0; k++) @(negedge aclk);
    if (r_exp.size() != 0) begin
      fail_evt("r_drain_timeout");
      r_exp.delete();
    end
  endtask

  // Apply wb_* beats as a burst; model update and expected B derived from the rules.
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len);
    logic [31:0] a;
    bit err, ok;
    b_rsp_t eb;
    err = 0;
    for (int n = 0; n <= len; n++) begin
      a = addr + 32'(n * 8);
      if (in_rng(a)) begin
        for (int b = 0; b < 8; b++)
          if (wb_strb[n][b]) model[widx(a)][b*8 +: 8] = wb_data[n][b*8 +: 8];
      end else err = 1;
      if (wb_last[n] != (n == len)) err = 1;
    end
    eb.id = id;
    eb.resp = err ? 2'b10 : 2'b00;
    b_exp.push_back(eb);
    @(posedge aclk);
    #1;
    awid = id; awaddr = addr; awlen = 4'(len); awvalid = 1'b1;
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge aclk);
      if (awready) ok = 1;
    end
    if (!ok) fail_evt("aw_handshake_timeout");
    @(posedge aclk);
    #1;
    awvalid = 1'b0;
    for (int n = 0; n <= len; n++) begin
      wvalid = 1'b1; wdata = wb_data[n]; wstrb = wb_strb[n]; wlast = wb_last[n];
      ok = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
        @(negedge aclk);
        if (wready) ok = 1;
      end
      if (!ok) fail_evt("w_beat_timeout");
      if (n == len) begin
        exp_b_cyc = cyc + 1;
        exp_b_v = 1;
      end
      @(posedge aclk);
      #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    for (int k = 0; k < 200 && b_exp.size() != 0; k++) @(negedge aclk);
    if (b_exp.size() != 0) begin
      fail_evt("b_drain_timeout");
      b_exp.delete();
    end
  endtask

  initial begin
    int len;
    logic [31:0] addr;
    bit ok;
    areset = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    clear_model();
    #1 areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_arready", arready, 1'b0);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_rid", rid, 4'h0);
    chk("rst_bid", bid, 4'h0);
    chk("rst_rdata", rdata, 64'd0);
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    chk("arready_before_edge", arready, 1'b0);
    @(negedge aclk);
    chk("arready_after_rst", arready, 1'b1);
    chk("awready_after_rst", awready, 1'b1);

    // Four-beat write then read back
    rr_mode = 0; br_mode = 0;
    for (int n = 0; n < 4; n++) begin
      wb_data[n] = 64'(n + 1) * 64'h11; wb_strb[n] = 8'hFF; wb_last[n] = (n == 3);
    end
    write_burst(4'h2, BASE, 3);
    read_burst(4'h5, BASE, 3);

    // Partial strobe over an all-ones word
    wb_data[0] = '1; wb_strb[0] = 8'hFF; wb_last[0] = 1'b1;
    write_burst(4'h1, BASE, 0);
    wb_data[0] = 64'd0; wb_strb[0] = 8'h0F;
    write_burst(4'h1, BASE, 0);
    read_burst(4'h6, BASE, 0);

    // Burst running off the top of memory
    read_burst(4'h7, BASE + 32'((DEPTH - 2) * 8), 3);

    // Early wlast on beat 1 of a four-beat burst
    for (int n = 0; n < 4; n++) begin
      wb_data[n] = {$urandom, $urandom}; wb_strb[n] = 8'hFF; wb_last[n] = (n == 1) || (n == 3);
    end
    write_burst(4'h9, BASE + 32'h20, 3);
    read_burst(4'h3, BASE + 32'h20, 3);

    // Gapped reads under a toggling rready
    rr_mode = 1; br_mode = 1;
    read_burst(4'hA, BASE, 7);

    // Randomised mix of reads and writes, some out of range or malformed
    rr_mode = 2; br_mode = 2;
    for (int it = 0; it < 60; it++) begin
      len = int'($urandom_range(0, 15));
      addr = BASE - 32'd64 + 32'(8 * $urandom_range(0, 28));
      if ($urandom_range(0, 1) == 1) begin
        for (int n = 0; n <= len; n++) begin
          wb_data[n] = {$urandom, $urandom};
          wb_strb[n] = 8'($urandom);
          wb_last[n] = (n == len);
        end
        if ($urandom_range(0, 4) == 0) begin
          int fb;
          fb = int'($urandom_range(0, 15)) % (len + 1);
          wb_last[fb] = ~wb_last[fb];
        end
        write_burst(4'($urandom), addr, len);
      end else begin
        read_burst(4'($urandom), addr, len);
      end
    end

    // Reset in the middle of an eight-beat read
    rr_mode = 1; br_mode = 0;
    issue_ar(4'h3, BASE, 7);
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge aclk);
      if (r_exp.size() <= 6) ok = 1;
    end
    if (!ok) fail_evt("mid_burst_wait_timeout");
    @(posedge aclk);
    #2 areset = 1'b1;
    #1;
    chk("midrst_rvalid", rvalid, 1'b0);
    chk("midrst_arready", arready, 1'b0);
    chk("midrst_rdata", rdata, 64'd0);
    r_exp.delete();
    clear_model();
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    chk("midrst_arready_hold", arready, 1'b0);
    chk("midrst_no_rvalid", rvalid, 1'b0);
    @(negedge aclk);
    chk("midrst_arready_back", arready, 1'b1);
    rr_mode = 0;
    read_burst(4'h4, BASE, 0);
    read_burst(4'h8, BASE + 32'h20, 1);

    repeat (5) @(posedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/apb2axi_axi_responder.md
# apb2axi_axi_responder

AXI3 subordinate responder for the APB2AXI bridge, single clock domain (ACLK). It accepts AR and AW/W traffic from the read and write builders and serves it from a small internal word memory. It returns R beats and B responses toward the response collector. Its roles are to close the AXI loop in block-level and top-level benches and to stress the response path with configurable inter-beat gaps and SLVERR injection.

## Interface
- TAG_W, default 4: width of ARID/RID/AWID/BID.
- ADDR_W, default 32: AXI address width.
- DATA_W, default 64: data width; one beat = DATA_W/8 bytes.
- MEM_DEPTH, default 16: words of internal memory, power of two.
- BASE_ADDR, default 0: byte address of word 0; must be DATA_W/8 aligned.
- RVALID_GAP, default 0: idle cycles inserted after each accepted non-last R beat.
- aclk  in  1  sole clock, rising edge.
- areset  in  1  asynchronous, active-high reset.
- arid/araddr/arlen/arvalid  in  TAG_W/ADDR_W/4/1  read address channel.
- arready  out  1.
- rid/rdata/rresp/rlast/rvalid  out  TAG_W/DATA_W/2/1/1  read data channel.
- rready  in  1.
- awid/awaddr/awlen/awvalid  in  TAG_W/ADDR_W/4/1  write address channel.
- awready  out  1.
- wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  write data channel.
- wready  out  1.
- bid/bresp/bvalid  out  TAG_W/2/1  write response channel.
- bready  in  1.

## Operation
- Bursts are INCR, full width. Size and burst fields are not ported. Beat n address = captured addr + n*(DATA_W/8).
- In range means BASE_ADDR <= addr < BASE_ADDR + MEM_DEPTH*DATA_W/8.
- Word index = (addr - BASE_ADDR) >> log2(DATA_W/8).
- Read and write FSMs are independent and may run concurrently. Each supports one outstanding burst.
- Read FSM states: R_IDLE, R_DATA, R_GAP.
  - R_IDLE: arready=1. On arvalid&&arready, capture arid, araddr and arlen; clear beat_cnt; go to R_DATA.
  - R_DATA: rvalid=1, rid=captured id, rdata=mem[index] (0 if out of range), rresp=00 if in range else 10 (SLVERR), rlast=(beat_cnt==len).
  - R_DATA on rready with rlast: go to R_IDLE.
  - R_DATA on rready without rlast: beat_cnt++ and address += DATA_W/8. Go to R_GAP if RVALID_GAP>0, else stay in R_DATA.
  - R_GAP: rvalid=0 for exactly RVALID_GAP cycles, then R_DATA.
  - R outputs are held stable while rvalid && !rready.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On handshake, capture id, addr and len; clear beat_cnt and err; go to W_DATA.
  - W_DATA: wready=1. On each wvalid&&wready, write bytes whose wstrb bit is set into mem[index] if in range; set err if out of range.
  - W_DATA protocol error: set err if wlast != (beat_cnt==len).
  - W_DATA: after the beat where beat_cnt==len, go to W_RESP. wlast never terminates a burst early.
  - W_RESP: bvalid=1, bid=captured id, bresp = err ? 10 : 00. On bready, go to W_IDLE.
- Memory contents reset to 0.
- Same-cycle write beat and read beat to one word: the read returns the old value; the write is visible from the next cycle.

## Timing
- Every output is registered or decoded from registered state. No combinational path from any input to any output.
- Reset values: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rlast=0, rresp=00, bresp=00, rid=0, bid=0, rdata=0. Memory is all 0.
- arready and awready rise in the first cycle after areset deasserts.
- AR-to-first-R latency: AR handshake in cycle t gives rvalid=1 in cycle t+1.
- With rready=1 and RVALID_GAP=0, a burst of arlen+1 beats occupies cycles t+1 .. t+1+arlen, and arready returns in the following cycle.
- With gaps, consecutive beats are spaced 1+RVALID_GAP cycles apart.
- Last W beat in cycle t gives bvalid=1 in cycle t+1. bvalid is held until bready.
- arready=0 outside R_IDLE; awready=0 outside W_IDLE; wready=0 outside W_DATA.
- areset mid-burst: all FSMs return to IDLE immediately, outputs take reset values, and the in-flight burst is discarded with no R or B output.

## Test plan
- Write 4 beats (awaddr=0x0, awlen=3, wstrb all 1s, data 0x11..0x44), then read arlen=3 from 0x0. Required: bresp=00; R beats 0x11..0x44 with rresp=00; rlast only on beat 3; rid=arid.
- Partial strobe: word 0 holds 0xFFFF_FFFF_FFFF_FFFF; write 0 with wstrb=0x0F; read back. Required: 0xFFFF_FFFF_0000_0000.
- Burst crossing the top of memory: araddr=BASE+(MEM_DEPTH-2)*8, arlen=3. Required: beats 0-1 have rresp=00; beats 2-3 have rresp=10 and rdata=0.
- RVALID_GAP=2 with rready toggled every cycle. Required: beats are never lost or duplicated; R outputs are stable under stall; each next rvalid arrives no earlier than 3 cycles after the previous handshake.
- wlast asserted on beat 1 of an awlen=3 burst. Required: burst still takes 4 beats and bresp=10.
- areset asserted at beat 2 of an 8-beat read. Required: rvalid=0 immediately; arready=1 the cycle after reset release; a fresh read of a previously written word returns 0.
